// File: rtl/hazard_pkg.sv
// hazard_pkg: state type, register constants and the load-use predicate shared by hazard_ctrl
package hazard_pkg;
  typedef enum logic {RUN, MD_WAIT} state_t;
  localparam int DEF_REG_AW = 5;
  localparam logic [DEF_REG_AW-1:0] ZERO_REG = '0;
  function automatic logic load_use_f(
    input logic                  mem_read,
    input logic [DEF_REG_AW-1:0] ex_rt,
    input logic [DEF_REG_AW-1:0] id_rs,
    input logic [DEF_REG_AW-1:0] id_rt,
    input logic                  uses_rt
  );
    return mem_read && ex_rt != ZERO_REG && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt));
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard sources in, PC / IF/ID / ID/EXE write and flush controls out
interface hazard_ctrl_if #(parameter int REG_AW = hazard_pkg::DEF_REG_AW);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] ex_rt;
  logic              id_uses_rt;
  logic              id_md_start;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idexe_write;
  logic              idexe_flush;
  logic              md_busy;
  modport master (
    output id_rs, id_rt, ex_rt, id_uses_rt, id_md_start, ex_mem_read, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idexe_write, idexe_flush, md_busy
  );
  modport slave (
    input  id_rs, id_rt, ex_rt, id_uses_rt, id_md_start, ex_mem_read, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idexe_write, idexe_flush, md_busy
  );
endinterface

// File: rtl/hazard_ctrl_md_timer.sv
// md_timer: loadable down-counter timing how long a mul/div holds EX; done when one cycle remains
module md_timer #(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_done
);
  localparam int CW = $clog2(MD_LATENCY) + 1;
  logic [CW-1:0] r_cnt;
  // load on issue, count down while waiting, hold at zero so it never underflows
  always_ff @(posedge clk)
    r_cnt <= rst ? '0 : i_load ? CW'(MD_LATENCY - 1) : (i_dec && r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
  assign o_done = r_cnt == CW'(1);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and mul/div occupancy control; HAZARD_STATS_EN adds event counters
module hazard_ctrl import hazard_pkg::*; #(
  parameter int MD_LATENCY = 4,
  parameter int REG_AW     = DEF_REG_AW
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]  stall_cnt,
  output logic [31:0]  flush_cnt,
  output logic [31:0]  md_cnt
`endif
);
  state_t            r_state;
  state_t            w_next;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_ex_rt;
  logic              w_load_use;
  logic              w_md_load;
  logic              w_md_dec;
  logic              w_md_done;
  assign w_rs       = bus.id_rs;
  assign w_rt       = bus.id_rt;
  assign w_ex_rt    = bus.ex_rt;
  assign w_load_use = load_use_f(bus.ex_mem_read, w_ex_rt, w_rs, w_rt, bus.id_uses_rt);
  md_timer #(.MD_LATENCY(MD_LATENCY)) u_md_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_md_load),
    .i_dec  (w_md_dec),
    .o_done (w_md_done)
  );
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? RUN : w_next;
  // next state and pipeline controls; reset wins, then the mul/div wait, then branch > load-use > mul/div issue
  always_comb begin
    w_next          = r_state;
    w_md_load       = 1'b0;
    w_md_dec        = 1'b0;
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.idexe_write = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idexe_flush = 1'b0;
    bus.md_busy     = 1'b0;
    if (rst) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idexe_write = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idexe_flush = 1'b1;
    end else if (r_state == MD_WAIT) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idexe_write = 1'b0;
      bus.md_busy     = 1'b1;
      w_md_dec        = 1'b1;
      w_next          = w_md_done ? RUN : MD_WAIT;
    end else if (bus.ex_branch_taken) begin
      bus.ifid_flush  = 1'b1;
      bus.idexe_flush = 1'b1;
    end else if (w_load_use) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idexe_flush = 1'b1;
    end else if (bus.id_md_start) begin
      w_md_load = 1'b1;
      w_next    = MD_WAIT;
    end
  end
`ifdef HAZARD_STATS_EN
  logic w_stall;
  logic w_flush;
  logic w_md_cyc;
  assign w_md_cyc = r_state == MD_WAIT;
  assign w_flush  = r_state == RUN && bus.ex_branch_taken;
  assign w_stall  = r_state == RUN && !bus.ex_branch_taken && w_load_use;
  // saturating event counters
  always_ff @(posedge clk)
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      md_cnt    <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(w_stall && stall_cnt != '1);
      flush_cnt <= flush_cnt + 32'(w_flush && flush_cnt != '1);
      md_cnt    <= md_cnt + 32'(w_md_cyc && md_cnt != '1);
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a cycle-count reference model
module tb_hazard_ctrl;
  localparam int LAT = 4;
  localparam logic [5:0] E_RUN   = 6'b110100;
  localparam logic [5:0] E_STALL = 6'b000110;
  localparam logic [5:0] E_FLUSH = 6'b111110;
  localparam logic [5:0] E_BUSY  = 6'b000001;
  localparam logic [5:0] E_RST   = 6'b001010;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [5:0] outs;
  hazard_ctrl_if #(.REG_AW(5)) bus ();
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt, md_cnt;
`endif
  hazard_ctrl #(.MD_LATENCY(LAT), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .md_cnt    (md_cnt)
`endif
  );
  // {pc_write, ifid_write, ifid_flush, idexe_write, idexe_flush, md_busy}
  assign outs = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idexe_write, bus.idexe_flush, bus.md_busy};
  always #5 clk = ~clk;

  task automatic idle();
    bus.id_rs = '0;
    bus.id_rt = '0;
    bus.ex_rt = '0;
    bus.id_uses_rt = 1'b0;
    bus.id_md_start = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_branch_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== E_RST) begin errors++; $display("FAIL reset_hold[%0d] got %b want %b", i, outs, E_RST); end
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== E_RUN) begin errors++; $display("FAIL reset_release[%0d] got %b want %b", i, outs, E_RUN); end
      tick();
    end
  endtask

  task automatic test_load_use();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8;
    @(negedge clk);
    checks++;
    if (outs !== E_STALL) begin errors++; $display("FAIL load_use_rs got %b want %b", outs, E_STALL); end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (outs !== E_RUN) begin errors++; $display("FAIL after_load_use got %b want %b", outs, E_RUN); end
    tick();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_rt = 5'd5; bus.id_uses_rt = 1'b1; bus.id_rs = 5'd2;
    @(negedge clk);
    checks++;
    if (outs !== E_STALL) begin errors++; $display("FAIL load_use_rt got %b want %b", outs, E_STALL); end
    tick();
    idle();
  endtask

  task automatic test_no_hazard();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
    @(negedge clk);
    checks++;
    if (outs !== E_RUN) begin errors++; $display("FAIL zero_reg_load got %b want %b", outs, E_RUN); end
    tick();
    bus.ex_rt = 5'd9; bus.id_rt = 5'd9; bus.id_uses_rt = 1'b0; bus.id_rs = 5'd3;
    @(negedge clk);
    checks++;
    if (outs !== E_RUN) begin errors++; $display("FAIL rt_not_used got %b want %b", outs, E_RUN); end
    tick();
    idle();
  endtask

  task automatic test_branch_priority();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8;
    bus.id_md_start = 1'b1; bus.ex_branch_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== E_FLUSH) begin errors++; $display("FAIL branch_priority got %b want %b", outs, E_FLUSH); end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (outs !== E_RUN) begin errors++; $display("FAIL after_branch got %b want %b", outs, E_RUN); end
    tick();
  endtask

  task automatic test_muldiv();
    bus.id_md_start = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== E_RUN) begin errors++; $display("FAIL md_issue got %b want %b", outs, E_RUN); end
    tick();
    bus.ex_branch_taken = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd4; bus.id_rs = 5'd4;
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== E_BUSY) begin errors++; $display("FAIL md_wait[%0d] got %b want %b", i, outs, E_BUSY); end
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if (outs !== E_RUN) begin errors++; $display("FAIL md_done got %b want %b", outs, E_RUN); end
    tick();
  endtask

  task automatic test_reset_mid_md();
    bus.id_md_start = 1'b1;
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (outs !== E_BUSY) begin errors++; $display("FAIL mid_md_wait1 got %b want %b", outs, E_BUSY); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== E_RST) begin errors++; $display("FAIL mid_md_reset got %b want %b", outs, E_RST); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== E_RUN) begin errors++; $display("FAIL after_mid_reset[%0d] got %b want %b", i, outs, E_RUN); end
      tick();
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    idle();
    tick();
    @(negedge clk);
    checks++;
    if ({stall_cnt, flush_cnt, md_cnt} !== 96'd0) begin
      errors++; $display("FAIL stats_reset got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, md_cnt);
    end
    rst = 1'b0;
    tick();
    bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8;
    tick();
    idle();
    bus.ex_branch_taken = 1'b1;
    tick();
    idle();
    bus.id_md_start = 1'b1;
    tick();
    idle();
    for (int i = 0; i < LAT; i++) tick();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 32'd1) begin errors++; $display("FAIL stats_stall got %0d want 1", stall_cnt); end
    checks++;
    if (flush_cnt !== 32'd1) begin errors++; $display("FAIL stats_flush got %0d want 1", flush_cnt); end
    checks++;
    if (md_cnt !== 32'(LAT - 1)) begin errors++; $display("FAIL stats_md got %0d want %0d", md_cnt, LAT - 1); end
    tick();
  endtask
`endif

  task automatic test_random();
    int left = 0;
    int m_st = 0;
    int m_fl = 0;
    int m_md = 0;
    logic lu;
    logic [5:0] exp;
    for (int i = 0; i < 400; i++) begin
      rst = (i == 0) || ($urandom_range(0, 49) == 0);
      bus.id_rs = 5'($urandom_range(0, 3));
      bus.id_rt = 5'($urandom_range(0, 3));
      bus.ex_rt = 5'($urandom_range(0, 3));
      bus.id_uses_rt = 1'($urandom_range(0, 1));
      bus.ex_mem_read = 1'($urandom_range(0, 1));
      bus.id_md_start = ($urandom_range(0, 5) == 0);
      bus.ex_branch_taken = ($urandom_range(0, 5) == 0);
      lu = bus.ex_mem_read && bus.ex_rt != 0 &&
           (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
      exp = rst ? E_RST : left > 0 ? E_BUSY : bus.ex_branch_taken ? E_FLUSH : lu ? E_STALL : E_RUN;
      @(negedge clk);
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL random[%0d] got %b want %b", i, outs, exp); end
`ifdef HAZARD_STATS_EN
      if (i > 0) begin
        checks++;
        if (stall_cnt !== 32'(m_st) || flush_cnt !== 32'(m_fl) || md_cnt !== 32'(m_md)) begin
          errors++;
          $display("FAIL random_stats[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", i, stall_cnt, flush_cnt, md_cnt, m_st, m_fl, m_md);
        end
      end
`endif
      if (rst) begin
        left = 0; m_st = 0; m_fl = 0; m_md = 0;
      end else if (left > 0) begin
        left--; m_md++;
      end else if (bus.ex_branch_taken) m_fl++;
      else if (lu) m_st++;
      else if (bus.id_md_start) left = LAT - 1;
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_priority();
    test_muldiv();
    test_reset_mid_md();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Control-side counterpart of the ID/EXE pipeline register in the 32-bit pipelined MIPS.
- Computes the write-enable and flush controls consumed by the PC, IF/ID and ID/EXE registers:
  - load-use stalls;
  - taken-branch flushes;
  - multi-cycle multiply/divide occupancy in EX.
- Small FSM plus latency counter; sits beside the ID stage.

Parameters:
- MD_LATENCY, 4, cycles a mul/div occupies EX (legal range 2..16).
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_rs  in  REG_AW  rs field of the instruction in ID.
- id_rt  in  REG_AW  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- id_md_start  in  1  ID instruction is mul/div.
- ex_mem_read  in  1  instruction in EX is a load (M-bus read bit of ID/EXE output).
- ex_rt  in  REG_AW  destination of the load in EX.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clear.
- idexe_write  out  1  ID/EXE load enable.
- idexe_flush  out  1  ID/EXE clear (inserts bubble).
- md_busy  out  1  high while FSM is in MD_WAIT.

Behaviour:
- Reset: clk and rst as stated above. On rst, state goes to RUN and the counter to 0.
- Outputs while rst is high: pc_write=0, ifid_write=0, idexe_write=0, ifid_flush=1, idexe_flush=1, md_busy=0.
- Outputs are combinational from the registered state and current inputs; state and counter update on posedge clk.
- Hazard terms:
  - load_use = ex_mem_read and ex_rt != 0 and (ex_rt == id_rs, or (id_uses_rt and ex_rt == id_rt)).
  - A load targeting $0 is never a hazard.
- RUN, priority order:
  1. ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idexe_write=1, idexe_flush=1. Stay RUN. id_md_start and load_use are ignored, because the ID instruction is squashed.
  2. load_use: pc_write=0, ifid_write=0, idexe_write=1, idexe_flush=1 (one bubble). Stay RUN. The hazard self-clears next cycle when the load reaches MEM.
  3. id_md_start: all writes=1, no flush. On the edge, load counter with MD_LATENCY-1 and go to MD_WAIT.
  4. Otherwise: all writes=1, flushes=0.
  - Combined cases: load_use with id_md_start gives load stall only, and the mul/div issues on a later cycle. Branch with load_use gives a branch flush only.
- MD_WAIT:
  - Outputs: pc_write=0, ifid_write=0, idexe_write=0, flushes=0, md_busy=1.
  - Counter decrements each cycle. When the counter is 1, next state is RUN with counter 0.
  - Total EX occupancy is MD_LATENCY cycles, counting the issue edge.
  - ex_branch_taken, load_use and id_md_start are ignored here; EX holds the mul/div, so none are valid.
- Reset mid-MD_WAIT returns to RUN immediately, and the rst output values above apply in that cycle.
- Counter width is $clog2(MD_LATENCY)+1. It never underflows.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, add three outputs: stall_cnt (32), flush_cnt (32), md_cnt (32).
- Update rules, all on posedge clk and all saturating at 0xFFFFFFFF:
  - stall_cnt +1 each cycle a load-use stall is applied.
  - flush_cnt +1 each branch flush.
  - md_cnt +1 each MD_WAIT cycle.
- rst clears all three counters.
- When undefined, these ports and their logic are absent.

Decomposition:
- Package hazard_pkg holds:
  - state enum {RUN, MD_WAIT};
  - REG_AW default;
  - constant ZERO_REG = 0;
  - a function computing load_use.
- One natural sub-module, md_timer: loadable down-counter with a done flag, parameterised by MD_LATENCY. The FSM stays in hazard_ctrl.

Test Plan:
- Reset: hold rst 2 cycles, release, idle inputs -> during rst all writes 0 and flushes 1; after release all writes 1, flushes 0, md_busy 0.
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle -> pc_write=0, ifid_write=0, idexe_flush=1 that cycle; next cycle, with ex_mem_read=0, normal flow.
- $0 and rt-not-used:
  - ex_rt=0, id_rs=0 -> no stall.
  - ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
- Branch priority: ex_branch_taken=1 together with load_use and id_md_start -> ifid_flush=1, idexe_flush=1, pc_write=1; md_busy stays 0 next cycle.
- Mul/div, MD_LATENCY=4: pulse id_md_start -> md_busy=1 for exactly 3 cycles with all writes 0, then RUN.
- Reset mid-op: assert rst during 2nd MD_WAIT cycle -> md_busy=0 at once; after release, RUN. Repeat with HAZARD_STATS_EN -> counters read 0 after reset and 1/1/3 after one stall, one branch, one mul/div.
